// File: rtl/ddr_wr_pkg.sv
// Shared types and address helper for the DDR burst writer.
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } ddr_wr_state_e;

  // Default 256-bit datapath; modules with other widths compute their own.
  localparam int DEF_DATA_WIDTH = 256;
  localparam int BYTES_PER_BEAT = DEF_DATA_WIDTH / 8;

  function automatic logic [63:0] burst_addr(input logic [63:0] base,
                                             input logic [31:0] idx,
                                             input logic [31:0] burst_bytes);
    return base + ({32'd0, idx} * {32'd0, burst_bytes});
  endfunction

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// Burst index bookkeeping and frame-relative burst address generation.
// DDR_WR_PINGPONG_EN adds a buffer select that flips at each completed frame.
module ddr_wr_addr_gen
  import ddr_wr_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 28,
  parameter int          BURST_LEN    = 16,
  parameter int          BURST_BYTES  = 512,
  parameter logic [63:0] FRAME_BASE   = 64'h0,
  parameter int          FRAME_BEATS  = 57600,
  parameter logic [63:0] FRAME_STRIDE = 64'h0020_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  advance,
  output logic                  last_burst,
  output logic [ADDR_WIDTH-1:0] addr
`ifdef DDR_WR_PINGPONG_EN
  ,
  output logic                  buf_sel
`endif
);

  localparam int BURSTS = FRAME_BEATS / BURST_LEN;

  logic [31:0] burst_idx;
  logic [63:0] base_sel;

  assign last_burst = (burst_idx == 32'(BURSTS - 1));

`ifdef DDR_WR_PINGPONG_EN
  assign base_sel = FRAME_BASE + (buf_sel ? FRAME_STRIDE : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sel <= 1'b0;
    end else if (advance && last_burst && !restart) begin
      buf_sel <= ~buf_sel;
    end
  end
`else
  assign base_sel = FRAME_BASE;
`endif

  // Address wraps naturally at the AXI address width.
  assign addr = ADDR_WIDTH'(burst_addr(base_sel, burst_idx, 32'(BURST_BYTES)));

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_idx <= '0;
    end else if (restart) begin
      burst_idx <= '0;
    end else if (advance) begin
      burst_idx <= last_burst ? '0 : burst_idx + 32'd1;
    end
  end

endmodule

// File: rtl/ddr_burst_writer.sv
// Drains the write FIFO into fixed-length AXI4 write bursts, one burst in flight.
// Build option DDR_WR_PINGPONG_EN alternates between two frame buffers.
module ddr_burst_writer
  import ddr_wr_pkg::*;
#(
  parameter int          DATA_WIDTH   = 256,
  parameter int          ADDR_WIDTH   = 28,
  parameter int          BURST_LEN    = 16,
  parameter logic [63:0] FRAME_BASE   = 64'h0,
  parameter int          FRAME_BEATS  = 57600,
  parameter logic [63:0] FRAME_STRIDE = 64'h0020_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  output logic                    fifo_rd_en,
  input  logic                    fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic                    busy,
  output logic                    frame_done,
  output ddr_wr_state_e           state_dbg
`ifdef DDR_WR_PINGPONG_EN
  ,
  output logic                    wr_buf_idx
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and payload is held while valid & !ready.

  localparam int         BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int         BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam logic [7:0] LAST_BEAT   = 8'(BURST_LEN - 1);

  if (FRAME_BEATS % BURST_LEN != 0) begin : g_bad_frame
    $error("ddr_burst_writer: FRAME_BEATS must be a multiple of BURST_LEN");
  end
  if (FRAME_STRIDE % BURST_BYTES != 0) begin : g_bad_stride
    $error("ddr_burst_writer: FRAME_STRIDE must be a multiple of the burst size");
  end

  ddr_wr_state_e             state, state_nxt;
  logic                      armed;
  logic                      pending_start;
  logic [7:0]                beat_cnt;
  logic                      launch;
  logic                      restart;
  logic                      advance;
  logic                      last_burst;
  logic [ADDR_WIDTH-1:0]     gen_addr;

  ddr_wr_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_LEN   (BURST_LEN),
    .BURST_BYTES (BURST_BYTES),
    .FRAME_BASE  (FRAME_BASE),
    .FRAME_BEATS (FRAME_BEATS),
    .FRAME_STRIDE(FRAME_STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .advance   (advance),
    .last_burst(last_burst),
    .addr      (gen_addr)
`ifdef DDR_WR_PINGPONG_EN
    ,
    .buf_sel   (wr_buf_idx)
`endif
  );

  assign axi_awlen = LAST_BEAT;
  assign axi_wdata = fifo_rd_data;
  assign axi_wstrb = '1;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_wlast   = 1'b0;
    axi_bready  = 1'b0;
    launch      = 1'b0;
    restart     = 1'b0;
    advance     = 1'b0;
    unique case (state)
      IDLE: begin
        // A fresh frame_start defers launch so the realign lands first.
        if (pending_start) begin
          restart = 1'b1;
        end else if (armed && fifo_rd_vld && !frame_start) begin
          launch    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_nxt = DATA;
      end
      DATA: begin
        axi_wvalid = fifo_rd_vld;
        axi_wlast  = (beat_cnt == LAST_BEAT);
        fifo_rd_en = fifo_rd_vld & axi_wready;
        if (fifo_rd_en && axi_wlast) state_nxt = RESP;
      end
      RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          advance   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      pending_start <= 1'b0;
      beat_cnt      <= '0;
      axi_awaddr    <= ADDR_WIDTH'(FRAME_BASE);
      frame_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= advance & last_burst;
      // Repeated pulses during a burst collapse into a single pending restart.
      if (state == IDLE) pending_start <= frame_start;
      else               pending_start <= pending_start | frame_start;
      if (restart)                      armed <= 1'b1;
      else if (advance && last_burst)   armed <= 1'b0;
      if (launch) axi_awaddr <= gen_addr;
      if (state == ADDR)   beat_cnt <= '0;
      else if (fifo_rd_en) beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule
